rs_syndrome: RTL and testbench
==============================

Name: rs_syndrome

Overview:
- First stage of the RS(255,247) decoder over GF(2^8), primitive polynomial 0x11D.
- Sits directly downstream of the encoder/channel and consumes the 8-bit codeword stream CX, one symbol per clock, highest-degree symbol first.
- Computes the 2T = 8 syndromes S_j = R(alpha^(FCR+j)) by Horner evaluation.
- Presents the syndromes, plus a nonzero flag, to the key-equation stage.

Parameters:
- N, 255, codeword length in symbols (2..255).
- T2, 8, number of parity symbols, which equals the number of syndromes.
- FCR, 1, exponent of the first consecutive generator root.

Ports:
- clk  in  1  rising-edge clock.
- stop  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; the first symbol of the codeword is on CX in the next cycle.
- CX  in  8  received symbol, sampled every cycle while busy.
- syn  out  8*T2  syndromes packed as S_j at bits [8j+7:8j]; held until the next syn_valid.
- syn_valid  out  1  one-cycle pulse; syn is new in that cycle.
- err_flag  out  1  OR of all syndromes being nonzero; updated with syn.
- busy  out  1  high while the block accepts symbols.
- counter  out  8  index of the symbol being accepted, 0..N-1.

Behaviour:
- Reset (stop high, asynchronous):
  - state to IDLE.
  - Syndrome accumulators, syn, err_flag, syn_valid, busy and counter all go to 0.
  - Reset mid-codeword discards the partial codeword; no syn_valid is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0; CX is ignored.
  - start moves to RUN with counter = 0.
- RUN (busy = 1), each clock:
  - If counter == 0: acc_j <= CX (load).
  - Otherwise: acc_j <= gfmul(acc_j, alpha^(FCR+j)) xor CX, for every j in 0..T2-1.
  - counter increments by 1.
  - The constant multipliers are combinational XOR networks; there are no table ROMs.
- Last symbol, counter == N-1:
  - The same edge writes the final value of acc_j into syn and sets err_flag.
  - State goes to DONE and counter clears to 0.
- DONE:
  - syn_valid = 1 for exactly this one cycle; busy = 0.
  - Next state is IDLE, or RUN if start is high this cycle. This allows back-to-back codewords with a one-cycle gap.
- Latency: syn_valid rises one clock edge after the edge that sampled the last symbol, i.e. N+1 cycles after the start cycle.
- start while in RUN:
  - Aborts the current codeword; CX in that cycle is discarded.
  - counter resets to 0 and the next cycle's CX is symbol 0.
  - syn and err_flag keep their previous values; no syn_valid is produced for the aborted word.
- start and stop high together: stop wins.
- syn and err_flag are stable between syn_valid pulses.
- counter is 8 bits; N-1 <= 254, so it never wraps.

Optional Feature:
- Macro: RS_SYNDROME_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [15:0].
  - err_cnt increments on each syn_valid whose err_flag is 1.
  - It saturates at 0xFFFF and is cleared by stop.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pulse stop, then start, then 255 zero symbols -> syn_valid pulses once, 256 cycles after the start cycle; syn = 0, err_flag = 0.
- Symbol 0 = 0x01, symbols 1..254 = 0x00 -> S_0 = alpha^-1 = 0x8E; S_j = alpha^-(1+j) for the other j; err_flag = 1.
- Symbols 0..253 = 0x00, symbol 254 = 0x01 -> every S_j = 0x01; err_flag = 1.
- Valid encoder codeword, then the same word with symbol 100 xor 0x5A:
  - First word: syn = 0, err_flag = 0.
  - Second word: all S_j nonzero, and S_(j+1)/S_j is constant.
  - With RS_SYNDROME_ERRCNT_EN defined, err_cnt = 1.
- Back-to-back codewords:
  - start asserted in the DONE cycle -> second syn_valid exactly 256 cycles after the first.
  - start asserted at counter = 120 -> the aborted word gives no syn_valid and the restarted word completes correctly.
- Assert stop at counter = 60 -> outputs go to 0 immediately (before the next clk edge); no syn_valid; the next start runs normally.

Source files
------------

// File: rtl/rs_syndrome.sv
// RS(255,247) syndrome stage over GF(2^8) (poly 0x11D): Horner-evaluates 2T syndromes per codeword.
// Optional macro RS_SYNDROME_ERRCNT_EN adds a saturating err_cnt output counting flagged codewords.
module rs_syndrome #(
    parameter int N   = 255,
    parameter int T2  = 8,
    parameter int FCR = 1
) (
    input  logic            clk,
    input  logic            stop,
    input  logic            start,
    input  logic [7:0]      CX,
    output logic [8*T2-1:0] syn,
    output logic            syn_valid,
    output logic            err_flag,
    output logic            busy,
    output logic [7:0]      counter
`ifdef RS_SYNDROME_ERRCNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(N - 1);

    // With a constant b this unrolls into a pure XOR network, no lookup tables.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         counter_q, counter_d;
    logic [T2-1:0][7:0] acc_q, acc_d;
    logic [T2-1:0][7:0] syn_q, syn_d;
    logic               err_flag_q, err_flag_d;
    logic [7:0]         horner [T2];
    logic               final_nz;

    for (genvar j = 0; j < T2; j++) begin : g_root
        localparam logic [7:0] ROOT = alpha_pow(FCR + j);
        assign horner[j] = gf_mul(acc_q[j], ROOT) ^ CX;
    end

    always_comb begin
        final_nz = 1'b0;
        for (int j = 0; j < T2; j++) begin
            if (horner[j] != 8'h00) final_nz = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        acc_d      = acc_q;
        syn_d      = syn_q;
        err_flag_d = err_flag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    counter_d = 8'd0;
                end
            end
            RUN: begin
                // A start here abandons the word; symbol 0 follows next cycle.
                if (start) begin
                    counter_d = 8'd0;
                end else begin
                    for (int j = 0; j < T2; j++) begin
                        acc_d[j] = (counter_q == 8'd0) ? CX : horner[j];
                    end
                    if (counter_q == LAST) begin
                        for (int j = 0; j < T2; j++) syn_d[j] = horner[j];
                        err_flag_d = final_nz;
                        state_d    = DONE;
                        counter_d  = 8'd0;
                    end else begin
                        counter_d = counter_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d   = start ? RUN : IDLE;
                counter_d = 8'd0;
            end
            default: begin
                state_d   = IDLE;
                counter_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge stop) begin
        if (stop) begin
            state_q    <= IDLE;
            counter_q  <= 8'd0;
            acc_q      <= '0;
            syn_q      <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            acc_q      <= acc_d;
            syn_q      <= syn_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign syn       = syn_q;
    assign err_flag  = err_flag_q;
    assign syn_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign counter   = counter_q;

`ifdef RS_SYNDROME_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == DONE && err_flag_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge stop) begin
        if (stop) err_cnt_q <= 16'd0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// Self-checking bench for rs_syndrome: random codewords against a power-sum syndrome model
// built from log/antilog tables, plus directed latency, abort and reset cases.
module tb_rs_syndrome;

    localparam int N   = 255;
    localparam int T2  = 8;
    localparam int FCR = 1;

    logic            clk = 1'b0;
    logic            stop;
    logic            start;
    logic [7:0]      CX;
    logic [8*T2-1:0] syn;
    logic            syn_valid;
    logic            err_flag;
    logic            busy;
    logic [7:0]      counter;
`ifdef RS_SYNDROME_ERRCNT_EN
    logic [15:0]     err_cnt;
`endif

    rs_syndrome #(.N(N), .T2(T2), .FCR(FCR)) dut (
        .clk       (clk),
        .stop      (stop),
        .start     (start),
        .CX        (CX),
        .syn       (syn),
        .syn_valid (syn_valid),
        .err_flag  (err_flag),
        .busy      (busy),
        .counter   (counter)
`ifdef RS_SYNDROME_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         valid_count = 0;
    int         valid_cyc = 0;
    int         start_cyc = 0;
    int         exp_errcnt = 0;
    int         exp_t [256];
    int         log_t [256];
    logic [7:0] cw [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (syn_valid === 1'b1) begin
            valid_count++;
            valid_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
    endfunction

    // S_j = sum_i r_i * alpha^((FCR+j) * degree_i), symbol 0 carrying degree N-1.
    function automatic logic [63:0] refSyndromes();
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int j = 0; j < T2; j++) begin
            s = 8'h00;
            for (int i = 0; i < N; i++) begin
                if (cw[i] != 8'h00)
                    s = s ^ 8'(exp_t[(log_t[cw[i]] + (FCR + j) * (N - 1 - i)) % 255]);
            end
            r[8*j +: 8] = s;
        end
        return r;
    endfunction

    // Non-systematic codeword c(x) = m(x) * g(x), then nerr random symbol corruptions.
    task automatic makeCodeword(input int nerr);
        logic [7:0] g [9];
        logic [7:0] c [N];
        logic [7:0] m;
        int         pos;
        for (int d = 0; d < 9; d++) g[d] = 8'h00;
        g[0] = 8'h01;
        for (int j = 0; j < T2; j++) begin
            for (int d = 8; d >= 0; d--)
                g[d] = ((d > 0) ? g[d-1] : 8'h00) ^ gfMul(g[d], 8'(exp_t[FCR + j]));
        end
        for (int d = 0; d < N; d++) c[d] = 8'h00;
        for (int a = 0; a < N - T2; a++) begin
            m = 8'($urandom);
            for (int b = 0; b <= T2; b++) c[a+b] = c[a+b] ^ gfMul(m, g[b]);
        end
        for (int i = 0; i < N; i++) cw[i] = c[N-1-i];
        for (int e = 0; e < nerr; e++) begin
            pos = $urandom_range(0, N - 1);
            cw[pos] = cw[pos] ^ 8'($urandom_range(1, 255));
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Feeds cw; abort_at >= 0 re-pulses start at that symbol index and returns.
    task automatic applyStimulus(input bit do_start, input int abort_at);
        if (do_start) begin
            start = 1'b1;
            start_cyc = cyc;
            stepCycle();
            start = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                start = 1'b1;
                CX = 8'($urandom);
                stepCycle();
                start = 1'b0;
                return;
            end
            CX = cw[i];
            if (i == 0 || i == N - 1) checkOutput("counter", 64'(counter), 64'(i));
            stepCycle();
        end
        CX = 8'($urandom);
    endtask

    task automatic finishWord(input string tag);
        logic [63:0] ref_syn;
        ref_syn = refSyndromes();
        checkOutput({tag, "_valid"}, 64'(syn_valid), 64'd1);
        checkOutput({tag, "_syn"}, syn, ref_syn);
        checkOutput({tag, "_flag"}, 64'(err_flag), 64'(ref_syn != 64'd0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        if (ref_syn != 64'd0 && exp_errcnt < 65535) exp_errcnt++;
    endtask

    initial begin
        int          first_valid;
        int          prev_count;
        logic [63:0] prev_syn;
        logic [7:0]  s0, s1;
        int          x;

        x = 1;
        log_t[0] = 0;
        for (int k = 0; k < 255; k++) begin
            exp_t[k] = x;
            log_t[x] = k;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11D;
        end
        exp_t[255] = 1;

        stop = 1'b1;
        start = 1'b0;
        CX = 8'h00;
        repeat (2) stepCycle();
        checkOutput("rst_syn", syn, 64'd0);
        checkOutput("rst_valid", 64'(syn_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_counter", 64'(counter), 64'd0);
        checkOutput("rst_flag", 64'(err_flag), 64'd0);
        stop = 1'b0;
        stepCycle();

        for (int i = 0; i < N; i++) cw[i] = 8'h00;
        applyStimulus(1'b1, -1);
        finishWord("zero");
        stepCycle();
        checkOutput("zero_latency", 64'(valid_cyc - start_cyc), 64'd256);
        checkOutput("zero_held", syn, 64'd0);
        checkOutput("idle_valid", 64'(syn_valid), 64'd0);

        cw[0] = 8'h01;
        applyStimulus(1'b1, -1);
        finishWord("first1");
        checkOutput("first1_s0", 64'(syn[7:0]), 64'h8E);
        stepCycle();

        cw[0] = 8'h00;
        cw[N-1] = 8'h01;
        applyStimulus(1'b1, -1);
        finishWord("last1");
        checkOutput("last1_all", syn, {8{8'h01}});
        stepCycle();

        makeCodeword(0);
        applyStimulus(1'b1, -1);
        finishWord("enc");
        checkOutput("enc_zero", syn, 64'd0);
        stepCycle();
        stop = 1'b1;
        #1;
        exp_errcnt = 0;
        stop = 1'b0;
        stepCycle();
        cw[100] = cw[100] ^ 8'h5A;
        applyStimulus(1'b1, -1);
        finishWord("enc_err");
        s0 = syn[7:0];
        s1 = syn[15:8];
        for (int j = 0; j < T2; j++)
            checkOutput("err_nonzero", 64'(syn[8*j +: 8] != 8'h00), 64'd1);
        for (int j = 0; j < T2 - 1; j++)
            checkOutput("err_ratio", 64'(gfMul(syn[8*(j+1) +: 8], s0)), 64'(gfMul(syn[8*j +: 8], s1)));
        stepCycle();
`ifdef RS_SYNDROME_ERRCNT_EN
        checkOutput("errcnt_one", 64'(err_cnt), 64'd1);
`endif

        makeCodeword(1);
        applyStimulus(1'b1, -1);
        finishWord("b2b_a");
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        first_valid = valid_cyc;
        makeCodeword(2);
        applyStimulus(1'b0, -1);
        finishWord("b2b_b");
        stepCycle();
        checkOutput("b2b_spacing", 64'(valid_cyc - first_valid), 64'd256);

        prev_syn = syn;
        prev_count = valid_count;
        makeCodeword(3);
        applyStimulus(1'b1, 120);
        checkOutput("abort_counter", 64'(counter), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd1);
        checkOutput("abort_syn", syn, prev_syn);
        makeCodeword(1);
        applyStimulus(1'b0, -1);
        finishWord("restart");
        stepCycle();
        checkOutput("abort_pulses", 64'(valid_count - prev_count), 64'd1);

        prev_count = valid_count;
        makeCodeword(2);
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            CX = cw[i];
            stepCycle();
        end
        checkOutput("pre_stop_counter", 64'(counter), 64'd60);
        stop = 1'b1;
        #1;
        checkOutput("stop_syn", syn, 64'd0);
        checkOutput("stop_flag", 64'(err_flag), 64'd0);
        checkOutput("stop_busy", 64'(busy), 64'd0);
        checkOutput("stop_counter", 64'(counter), 64'd0);
        checkOutput("stop_valid", 64'(syn_valid), 64'd0);
`ifdef RS_SYNDROME_ERRCNT_EN
        checkOutput("stop_errcnt", 64'(err_cnt), 64'd0);
`endif
        exp_errcnt = 0;
        repeat (2) stepCycle();
        stop = 1'b0;
        stepCycle();
        checkOutput("stop_pulses", 64'(valid_count - prev_count), 64'd0);

        for (int w = 0; w < 5; w++) begin
            makeCodeword($urandom_range(0, 3));
            if (w == 4) for (int i = 0; i < N; i++) cw[i] = 8'($urandom);
            applyStimulus(1'b1, -1);
            finishWord("rand");
            stepCycle();
        end
`ifdef RS_SYNDROME_ERRCNT_EN
        checkOutput("final_errcnt", 64'(err_cnt), 64'(exp_errcnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
